// File: rtl/loader_pkg.sv
// Shared state encoding and default widths for the LUT register-file loader.
package loader_pkg;
   localparam int DW_DEF = 8;
   localparam int AW_DEF = 2;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_SCAN = 2'd2;
endpackage

// File: rtl/dwell_timer.sv
// Free-running dwell counter: TICK marks the last cycle of each DWELL-cycle window.
module dwell_timer #(
   parameter int DWELL = 12000000,
   parameter int CW    = 24
) (
   input  logic CLKIN,
   input  logic RESET,
   input  logic EN,
   input  logic CLR,
   output logic TICK
);
   localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign TICK = EN && (cnt_q == LAST);

   // Next count: clear wins, wrap after the tick, otherwise advance while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (CLR || TICK) begin
         cnt_d = '0;
      end else if (EN) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge CLKIN or posedge RESET) begin
      if (RESET) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/regfile_loader.sv
// Fills the 4-entry LUT register file from a VALID/READY byte stream, then
// scans RADDR through every entry so the stored contents appear on J3.
module regfile_loader
   import loader_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int AW    = AW_DEF,
   parameter int DWELL = 12000000,
   parameter int CW    = 24
) (
   input  logic          CLKIN,
   input  logic          RESET,
   input  logic          START,
   input  logic [DW-1:0] DATA,
   input  logic          VALID,
   output logic          READY,
   output logic [AW-1:0] WADDR,
   output logic [DW-1:0] WDATA,
   output logic          WE,
   output logic [AW-1:0] RADDR,
   output logic          DONE
);
   // One extra count bit lets the final index be recognised without wrapping.
   localparam logic [AW:0] LAST_IDX = (AW + 1)'(2 ** AW - 1);

   state_t        state_q, state_d;
   logic [AW:0]   count_q, count_d;
   logic          we_q, we_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [AW-1:0] raddr_q, raddr_d;
   logic          done_q, done_d;
   logic          accept_s;
   logic          tick_s;
   logic          dwell_en_s;

   assign READY      = (state_q == ST_LOAD);
   assign accept_s   = READY && VALID && !START;
   assign dwell_en_s = (state_q == ST_SCAN) && !START;

   dwell_timer #(.DWELL(DWELL), .CW(CW)) u_dwell (
      .CLKIN (CLKIN),
      .RESET (RESET),
      .EN    (dwell_en_s),
      .CLR   (!dwell_en_s),
      .TICK  (tick_s)
   );

   // FSM, write counter and output next-state logic; START always restarts a load.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      raddr_d = raddr_q;
      done_d  = done_q;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               state_d = ST_LOAD;
               count_d = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (START) begin
               count_d = '0;
               raddr_d = '0;
               done_d  = 1'b0;
            end else if (accept_s) begin
               we_d    = 1'b1;
               waddr_d = count_q[AW-1:0];
               wdata_d = DATA;
               count_d = count_q + 1'b1;
               if (count_q == LAST_IDX) begin
                  state_d = ST_SCAN;
                  raddr_d = '0;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_SCAN: begin
            if (START) begin
               state_d = ST_LOAD;
               count_d = '0;
               raddr_d = '0;
               done_d  = 1'b0;
            end else if (tick_s) begin
               raddr_d = raddr_q + 1'b1;
            end else begin
               raddr_d = raddr_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = '0;
            raddr_d = '0;
            done_d  = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge CLKIN or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         raddr_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         raddr_q <= raddr_d;
         done_q  <= done_d;
      end
   end

   assign WE    = we_q;
   assign WADDR = waddr_q;
   assign WDATA = wdata_q;
   assign RADDR = raddr_q;
   assign DONE  = done_q;
endmodule

// File: tb/tb_regfile_loader.sv
// Bench for regfile_loader with a 4x8 register file model and a
// transaction-level reference of the load/scan behaviour.
module tb_regfile_loader;
   localparam int DW    = 8;
   localparam int AW    = 2;
   localparam int DEPTH = 4;
   localparam int DWELL = 3;
   localparam int CW    = 4;

   logic          CLKIN = 1'b0;
   logic          RESET;
   logic          START;
   logic [DW-1:0] DATA;
   logic          VALID;
   logic          READY;
   logic [AW-1:0] WADDR;
   logic [DW-1:0] WDATA;
   logic          WE;
   logic [AW-1:0] RADDR;
   logic          DONE;

   regfile_loader #(.DW(DW), .AW(AW), .DWELL(DWELL), .CW(CW)) dut (
      .CLKIN (CLKIN),
      .RESET (RESET),
      .START (START),
      .DATA  (DATA),
      .VALID (VALID),
      .READY (READY),
      .WADDR (WADDR),
      .WDATA (WDATA),
      .WE    (WE),
      .RADDR (RADDR),
      .DONE  (DONE)
   );

   always #5 CLKIN = ~CLKIN;

   logic [DW-1:0] rf [DEPTH];
   logic [DW-1:0] j3;
   always @(posedge CLKIN) if (WE) rf[WADDR] <= WDATA;
   assign j3 = rf[RADDR];

   int            tests = 0;
   int            fails = 0;
   bit            loading, scanning;
   int            wr_idx, scan_cycles;
   logic [DW-1:0] exp_mem [DEPTH];
   bit            pend;
   int            pend_a;
   logic [DW-1:0] pend_d;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, READY, 0);
      chk({tag, "_we"}, WE, 0);
      chk({tag, "_waddr"}, WADDR, 0);
      chk({tag, "_wdata"}, WDATA, 0);
      chk({tag, "_raddr"}, RADDR, 0);
      chk({tag, "_done"}, DONE, 0);
   endtask

   // One clock of stimulus; expectations come from the load/scan rules, with RADDR
   // derived arithmetically from the number of cycles spent scanning.
   task automatic step(input bit s, input bit v, input logic [DW-1:0] d);
      bit            acc;
      bit            old_pend;
      int            oa;
      logic [DW-1:0] od;
      START = s;
      VALID = v;
      DATA  = d;
      chk("ready", READY, loading);
      acc      = loading && v && !s;
      old_pend = pend;
      oa       = pend_a;
      od       = pend_d;
      @(posedge CLKIN);
      #1;
      if (old_pend) exp_mem[oa] = od;
      pend   = acc;
      pend_a = wr_idx;
      pend_d = d;
      chk("we", WE, acc);
      if (acc) begin
         chk("waddr", WADDR, wr_idx);
         chk("wdata", WDATA, d);
      end
      if (s) begin
         loading = 1; scanning = 0; wr_idx = 0; scan_cycles = 0;
      end else if (acc) begin
         wr_idx++;
         if (wr_idx == DEPTH) begin
            loading = 0; scanning = 1; scan_cycles = 0;
         end
      end else if (scanning) begin
         scan_cycles++;
      end
      chk("done", DONE, scanning);
      chk("raddr", RADDR, scanning ? (scan_cycles / DWELL) % DEPTH : 0);
      if (scanning) chk("j3", j3, exp_mem[(scan_cycles / DWELL) % DEPTH]);
   endtask

   initial begin
      int guard;
      RESET = 1'b1; START = 1'b0; VALID = 1'b0; DATA = 8'h00;
      loading = 0; scanning = 0; wr_idx = 0; scan_cycles = 0; pend = 0; pend_a = 0; pend_d = 8'h00;
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'h00;
      #11;
      chk_all_zero("por");
      #1 RESET = 1'b0;
      @(posedge CLKIN); #1;
      chk_all_zero("idle");

      // Asynchronous reset in the middle of a write cycle.
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'hC3);
      #3 RESET = 1'b1;
      #1 chk_all_zero("async_rst");
      pend = 0; loading = 0; scanning = 0;
      #1 RESET = 1'b0;
      @(posedge CLKIN); #1;

      // Back-to-back load followed by a full scan rotation.
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h11);
      step(1'b0, 1'b1, 8'h22);
      step(1'b0, 1'b1, 8'h33);
      step(1'b0, 1'b1, 8'h44);
      for (int i = 0; i < 13; i++) step(1'b0, 1'b0, 8'h00);

      // Gapped VALID.
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'hA5);
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h5A);
      step(1'b0, 1'b0, 8'h00);

      // Restart mid-load with VALID high: that byte is dropped.
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h01);
      step(1'b0, 1'b1, 8'h02);
      step(1'b1, 1'b1, 8'h03);
      step(1'b0, 1'b1, 8'h03);
      step(1'b0, 1'b1, 8'h04);
      step(1'b0, 1'b1, 8'h05);
      step(1'b0, 1'b1, 8'h06);

      // Restart from SCAN once RADDR reaches 2; old contents must survive.
      guard = 0;
      while (!(scanning && ((scan_cycles / DWELL) % DEPTH) == 2) && guard < 50) begin
         step(1'b0, 1'b0, 8'h00);
         guard++;
      end
      chk("scan_reach", guard < 50, 1);
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      for (int i = 0; i < DEPTH; i++) chk("retain", rf[i], exp_mem[i]);

      // Randomised traffic against the same reference.
      for (int n = 0; n < 400; n++)
         step($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));

      START = 1'b0; VALID = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
